// File: rtl/axi_rd_burst_seq_if.sv
// rtl/axi_rd_burst_seq_if.sv - AXI4 read address/data channel bundle for the burst sequencer
interface axi_rd_burst_seq_if #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic [ID_W-1:0]   m_arid;
    logic [3:0]        m_arcache;
    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arcache, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arcache, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );
endinterface

// File: rtl/axi_rd_burst_seq.sv
// rtl/axi_rd_burst_seq.sv - splits one read command into 4 KB-safe INCR bursts, streams R data out
module axi_rd_burst_seq #(
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int ARID_VAL  = 0,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [31:0]       ctrl_address,
    input  logic [15:0]       ctrl_bytes,
    output logic              status_valid,
    output logic [1:0]        status_resp,
    output logic              busy,
    axi_rd_burst_seq_if.master axi,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last
);
    localparam int BEAT_BYTES       = DATA_W / 8;
    localparam int OFF_W            = $clog2(BEAT_BYTES);
    localparam logic [31:0] OFF_MSK = 32'(BEAT_BYTES - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [16:0] beats_left_q, beats_left_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]  err_q, err_d;
    logic        ctrl_ready_q, ctrl_ready_d;
    logic        busy_q, busy_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        status_valid_q, status_valid_d;
    logic [1:0]  status_resp_q, status_resp_d;

    logic [16:0] beats_in;
    logic [12:0] room;
    logic [16:0] cand;
    logic [1:0]  rresp_map;
    logic [1:0]  err_tmp;
    logic        in_data;
    logic        r_hs;
    logic        final_burst;

    assign in_data     = (state_q == S_DATA);
    assign r_hs        = in_data && axi.m_rvalid && dout_ready;
    assign final_burst = (beats_left_q == {8'd0, len_q});

    // R channel is a straight wire to the data-out port while a burst is active
    assign axi.m_rready = in_data && dout_ready;
    assign dout_valid   = in_data && axi.m_rvalid;
    assign dout_data    = axi.m_rdata;
    assign dout_last    = dout_valid && (beat_cnt_q == 9'd1) && final_burst;

    assign ctrl_ready     = ctrl_ready_q;
    assign busy           = busy_q;
    assign status_valid   = status_valid_q;
    assign status_resp    = status_resp_q;
    assign axi.m_arvalid  = arvalid_q;
    assign axi.m_araddr   = araddr_q;
    assign axi.m_arlen    = arlen_q;
    assign axi.m_arsize   = 3'(OFF_W);
    assign axi.m_arburst  = 2'b01;
    assign axi.m_arid     = ID_W'(ARID_VAL);
    assign axi.m_arcache  = 4'b0011;

    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        beats_left_d   = beats_left_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_q;
        err_d          = err_q;
        araddr_d       = araddr_q;
        arlen_d        = arlen_q;
        status_resp_d  = status_resp_q;

        // Offset into the first beat widens the beat count; 17 bits holds the worst case
        beats_in  = (17'(ctrl_bytes) + 17'(ctrl_address & OFF_MSK) + 17'(BEAT_BYTES - 1)) >> OFF_W;
        room      = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFF_W;
        cand      = 17'(MAX_BEATS);
        if (17'(room) < cand)    cand = 17'(room);
        if (beats_left_q < cand) cand = beats_left_q;

        rresp_map = (axi.m_rresp == RESP_EXOKAY) ? RESP_OKAY : axi.m_rresp;
        err_tmp   = err_q;
        if (rresp_map > err_tmp) err_tmp = rresp_map;
        if ((axi.m_rlast != (beat_cnt_q == 9'd1)) && (err_tmp < RESP_SLVERR)) err_tmp = RESP_SLVERR;

        case (state_q)
            S_IDLE: begin
                if (ctrl_valid && ctrl_ready_q) begin
                    cur_addr_d   = ctrl_address & ~OFF_MSK;
                    beats_left_d = beats_in;
                    err_d        = RESP_OKAY;
                    state_d      = (ctrl_bytes == 16'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                len_d    = 9'(cand);
                araddr_d = cur_addr_q;
                arlen_d  = 8'(cand - 17'd1);
                state_d  = S_ADDR;
            end
            S_ADDR: begin
                if (axi.m_arready) begin
                    beat_cnt_d = len_q;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    err_d      = err_tmp;
                    if (beat_cnt_q == 9'd1) begin
                        beats_left_d = beats_left_q - {8'd0, len_q};
                        cur_addr_d   = cur_addr_q + (32'(len_q) << OFF_W);
                        state_d      = final_burst ? S_DONE : S_CALC;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ctrl_ready_d   = (state_d == S_IDLE);
        busy_d         = (state_d != S_IDLE);
        arvalid_d      = (state_d == S_ADDR);
        status_valid_d = (state_d == S_DONE);
        if ((state_d == S_DONE) && (state_q != S_DONE)) status_resp_d = err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cur_addr_q     <= '0;
            beats_left_q   <= '0;
            len_q          <= '0;
            beat_cnt_q     <= '0;
            err_q          <= RESP_OKAY;
            ctrl_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            arvalid_q      <= 1'b0;
            araddr_q       <= '0;
            arlen_q        <= '0;
            status_valid_q <= 1'b0;
            status_resp_q  <= RESP_OKAY;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            beats_left_q   <= beats_left_d;
            len_q          <= len_d;
            beat_cnt_q     <= beat_cnt_d;
            err_q          <= err_d;
            ctrl_ready_q   <= ctrl_ready_d;
            busy_q         <= busy_d;
            arvalid_q      <= arvalid_d;
            araddr_q       <= araddr_d;
            arlen_q        <= arlen_d;
            status_valid_q <= status_valid_d;
            status_resp_q  <= status_resp_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_burst_seq.sv
// tb/tb_axi_rd_burst_seq.sv - directed bench for axi_rd_burst_seq with a single-outstanding AXI read slave
module tb_axi_rd_burst_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_valid = 1'b0;
    logic        ctrl_ready;
    logic [31:0] ctrl_address = '0;
    logic [15:0] ctrl_bytes = '0;
    logic        status_valid;
    logic [1:0]  status_resp;
    logic        busy;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [63:0] dout_data;
    logic        dout_last;

    axi_rd_burst_seq_if #(.DATA_W(64), .ID_W(4)) bus ();

    axi_rd_burst_seq #(.DATA_W(64), .ID_W(4), .ARID_VAL(0), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .ctrl_address(ctrl_address), .ctrl_bytes(ctrl_bytes),
        .status_valid(status_valid), .status_resp(status_resp), .busy(busy),
        .axi(bus.master),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs (written only by test tasks)
    int          ar_delay = 0;
    bit          tog_en   = 1'b0;
    int          early_idx = -1;
    logic [1:0]  resp_tab [64];
    logic [31:0] exp_base = '0;
    int          dout0 = 0;
    int          gbeat0 = 0;

    // Monitor-owned counters; tasks work on deltas from snapshots
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int n_dout = 0, dout_bad = 0, n_last = 0, last_at = -1, n_status = 0;
    int stab_err = 0, rready_err = 0, cross_err = 0, n_arv = 0;
    logic [1:0]  st_resp = 2'b00;
    bit          ar_pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [7:0]  pend_len = '0;
    bit          ar_hs_n = 1'b0, r_hs_n = 1'b0, arv_n = 1'b0;
    logic [31:0] araddr_n = '0;
    logic [7:0]  arlen_n = '0;

    // Slave-owned state
    int          cyc = 0;
    int          gbeat = 0;
    int          stall_cnt = 0;
    bit          s_active = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_len = 0, s_beat = 0;
    int          ri;

    always @(negedge clk) begin
        if (rst_n) begin
            ar_hs_n  = bus.m_arvalid && bus.m_arready;
            r_hs_n   = bus.m_rvalid && bus.m_rready;
            arv_n    = bus.m_arvalid;
            araddr_n = bus.m_araddr;
            arlen_n  = bus.m_arlen;
            if (bus.m_arvalid) begin
                n_arv++;
                if (ar_pend && (bus.m_araddr !== pend_addr || bus.m_arlen !== pend_len)) stab_err++;
                ar_pend   = !bus.m_arready;
                pend_addr = bus.m_araddr;
                pend_len  = bus.m_arlen;
            end else begin
                ar_pend = 1'b0;
            end
            if (ar_hs_n) begin
                ar_addr_q.push_back(bus.m_araddr);
                ar_len_q.push_back(bus.m_arlen);
                if (int'(bus.m_araddr[11:0]) + (int'(bus.m_arlen) + 1) * 8 > 4096) cross_err++;
            end
            if (bus.m_rvalid && (bus.m_rready !== dout_ready)) rready_err++;
            if (dout_valid && dout_ready) begin
                if (dout_data !== {32'd0, exp_base + 32'((n_dout - dout0) * 8)}) dout_bad++;
                if (dout_last) begin
                    n_last++;
                    last_at = n_dout - dout0;
                end
                n_dout++;
            end
            if (status_valid) begin
                n_status++;
                st_resp = status_resp;
            end
        end else begin
            ar_hs_n = 1'b0;
            r_hs_n  = 1'b0;
            arv_n   = 1'b0;
            ar_pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            bus.m_arready = 1'b0;
            bus.m_rvalid  = 1'b0;
            bus.m_rlast   = 1'b0;
            bus.m_rresp   = 2'b00;
            bus.m_rdata   = '0;
            s_active      = 1'b0;
            stall_cnt     = 0;
            dout_ready    = 1'b1;
        end else begin
            if (r_hs_n) begin
                s_beat++;
                gbeat++;
                if (s_beat == s_len) s_active = 1'b0;
            end
            if (ar_hs_n) begin
                s_active  = 1'b1;
                s_addr    = araddr_n;
                s_len     = int'(arlen_n) + 1;
                s_beat    = 0;
                stall_cnt = 0;
            end else if (arv_n) begin
                stall_cnt++;
            end
            ri = gbeat - gbeat0;
            bus.m_arready = (stall_cnt >= ar_delay);
            bus.m_rvalid  = s_active;
            bus.m_rdata   = {32'd0, s_addr + 32'(s_beat * 8)};
            bus.m_rresp   = (ri >= 0 && ri < 64) ? resp_tab[ri] : 2'b00;
            bus.m_rlast   = s_active && ((s_beat == s_len - 1) != (ri == early_idx));
            dout_ready    = tog_en ? ~dout_ready : 1'b1;
        end
    end

    int a0, s0, v0, l0;

    task automatic fill_resp(input logic [1:0] r);
        for (int i = 0; i < 64; i++) resp_tab[i] = r;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] b, output int lat);
        bit acc;
        lat = -1;
        acc = 1'b0;
        a0 = ar_addr_q.size(); s0 = n_status; v0 = n_arv; l0 = n_last;
        dout0 = n_dout; gbeat0 = gbeat; exp_base = a & ~32'h7;
        @(posedge clk); #1;
        ctrl_valid = 1'b1; ctrl_address = a; ctrl_bytes = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (ctrl_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        ctrl_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept, required accept within 50 cycles");
        end else begin
            for (int i = 1; i < 3000 && lat < 0; i++) begin
                @(negedge clk);
                if (status_valid) lat = i;
            end
            n_checks++;
            if (lat < 0) begin
                n_fail++;
                $display("FAIL status_timeout: got no status_valid, required one within 3000 cycles");
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ctrl_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ctrl_ready: got %b required 1", ctrl_ready); end
        n_checks++; if (bus.m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b required 0", bus.m_arvalid); end
        n_checks++; if (status_valid !== 1'b0 || status_resp !== 2'b00) begin n_fail++; $display("FAIL rst_status: got %b/%b required 0/00", status_valid, status_resp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (bus.m_araddr !== 32'h0 || bus.m_arlen !== 8'h0) begin n_fail++; $display("FAIL rst_ar_fields: got %h/%h required 0/0", bus.m_araddr, bus.m_arlen); end
        n_checks++; if (bus.m_arsize !== 3'd3 || bus.m_arburst !== 2'b01 || bus.m_arcache !== 4'b0011 || bus.m_arid !== 4'd0)
            begin n_fail++; $display("FAIL ar_constants: got size %0d burst %b cache %b id %0d required 3 01 0011 0", bus.m_arsize, bus.m_arburst, bus.m_arcache, bus.m_arid); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ctrl_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got ready %b busy %b required 1 0", ctrl_ready, busy); end
    endtask

    task automatic test_single_burst;
        int lat;
        fill_resp(2'b00);
        run_cmd(32'h1000, 16'd128, lat);
        n_checks++; if (ar_addr_q.size() - a0 !== 1) begin n_fail++; $display("FAIL single_ar_count: got %0d required 1", ar_addr_q.size() - a0); end
        else begin
            n_checks++; if (ar_addr_q[a0] !== 32'h1000 || ar_len_q[a0] !== 8'd15) begin n_fail++; $display("FAIL single_ar: got %h len %0d required 1000 len 15", ar_addr_q[a0], ar_len_q[a0]); end
        end
        n_checks++; if (n_dout - dout0 !== 16) begin n_fail++; $display("FAIL single_beats: got %0d required 16", n_dout - dout0); end
        n_checks++; if (n_last - l0 !== 1 || last_at !== 15) begin n_fail++; $display("FAIL single_last: got %0d at %0d required 1 at 15", n_last - l0, last_at); end
        n_checks++; if (dout_bad !== 0) begin n_fail++; $display("FAIL single_data: got %0d bad words required 0", dout_bad); end
        n_checks++; if (st_resp !== 2'b00 || n_status - s0 !== 1) begin n_fail++; $display("FAIL single_status: got %b x%0d required 00 x1", st_resp, n_status - s0); end
    endtask

    task automatic test_unaligned;
        int lat;
        fill_resp(2'b00);
        run_cmd(32'h1004, 16'd8, lat);
        n_checks++; if (ar_addr_q.size() - a0 !== 1) begin n_fail++; $display("FAIL unal_ar_count: got %0d required 1", ar_addr_q.size() - a0); end
        else begin
            n_checks++; if (ar_addr_q[a0] !== 32'h1000 || ar_len_q[a0] !== 8'd1) begin n_fail++; $display("FAIL unal_ar: got %h len %0d required 1000 len 1", ar_addr_q[a0], ar_len_q[a0]); end
        end
        n_checks++; if (n_dout - dout0 !== 2 || last_at !== 1) begin n_fail++; $display("FAIL unal_beats: got %0d last %0d required 2 last 1", n_dout - dout0, last_at); end
        n_checks++; if (st_resp !== 2'b00) begin n_fail++; $display("FAIL unal_status: got %b required 00", st_resp); end
    endtask

    task automatic test_4kb_boundary;
        int lat;
        fill_resp(2'b00);
        run_cmd(32'h0FF0, 16'd64, lat);
        n_checks++; if (ar_addr_q.size() - a0 !== 2) begin n_fail++; $display("FAIL b4k_ar_count: got %0d required 2", ar_addr_q.size() - a0); end
        else begin
            n_checks++; if (ar_addr_q[a0] !== 32'h0FF0 || ar_len_q[a0] !== 8'd1) begin n_fail++; $display("FAIL b4k_ar0: got %h len %0d required ff0 len 1", ar_addr_q[a0], ar_len_q[a0]); end
            n_checks++; if (ar_addr_q[a0+1] !== 32'h1000 || ar_len_q[a0+1] !== 8'd5) begin n_fail++; $display("FAIL b4k_ar1: got %h len %0d required 1000 len 5", ar_addr_q[a0+1], ar_len_q[a0+1]); end
        end
        n_checks++; if (cross_err !== 0) begin n_fail++; $display("FAIL b4k_cross: got %0d crossings required 0", cross_err); end
        n_checks++; if (n_dout - dout0 !== 8 || last_at !== 7 || dout_bad !== 0) begin n_fail++; $display("FAIL b4k_beats: got %0d last %0d bad %0d required 8 7 0", n_dout - dout0, last_at, dout_bad); end
    endtask

    task automatic test_zero_bytes;
        int lat;
        run_cmd(32'h1234, 16'd0, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d required 1", lat); end
        n_checks++; if (n_arv - v0 !== 0 || n_dout - dout0 !== 0) begin n_fail++; $display("FAIL zero_no_ar: got arvalid cycles %0d beats %0d required 0 0", n_arv - v0, n_dout - dout0); end
        n_checks++; if (st_resp !== 2'b00 || n_status - s0 !== 1) begin n_fail++; $display("FAIL zero_status: got %b x%0d required 00 x1", st_resp, n_status - s0); end
    endtask

    task automatic test_errors;
        int lat;
        fill_resp(2'b00);
        resp_tab[18] = 2'b10;
        run_cmd(32'h2000, 16'd384, lat);
        n_checks++; if (ar_addr_q.size() - a0 !== 3 || n_dout - dout0 !== 48) begin n_fail++; $display("FAIL err_slv_bursts: got %0d ARs %0d beats required 3 48", ar_addr_q.size() - a0, n_dout - dout0); end
        n_checks++; if (st_resp !== 2'b10) begin n_fail++; $display("FAIL err_slv_status: got %b required 10", st_resp); end
        resp_tab[40] = 2'b11;
        run_cmd(32'h2000, 16'd384, lat);
        n_checks++; if (st_resp !== 2'b11 || ar_addr_q.size() - a0 !== 3) begin n_fail++; $display("FAIL err_dec_status: got %b ARs %0d required 11 3", st_resp, ar_addr_q.size() - a0); end
        fill_resp(2'b01);
        run_cmd(32'h2000, 16'd384, lat);
        n_checks++; if (st_resp !== 2'b00) begin n_fail++; $display("FAIL err_exokay_status: got %b required 00", st_resp); end
        fill_resp(2'b00);
    endtask

    task automatic test_ar_stall;
        int lat;
        int se;
        se = stab_err;
        ar_delay = 5;
        run_cmd(32'h3000, 16'd32, lat);
        ar_delay = 0;
        n_checks++; if (n_arv - v0 !== 6) begin n_fail++; $display("FAIL stall_arvalid_cycles: got %0d required 6", n_arv - v0); end
        n_checks++; if (stab_err - se !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes required 0", stab_err - se); end
        n_checks++; if (ar_addr_q.size() - a0 !== 1 || n_dout - dout0 !== 4 || st_resp !== 2'b00) begin n_fail++; $display("FAIL stall_result: got ARs %0d beats %0d resp %b required 1 4 00", ar_addr_q.size() - a0, n_dout - dout0, st_resp); end
    endtask

    task automatic test_rready_toggle;
        int lat;
        int re;
        re = rready_err;
        tog_en = 1'b1;
        run_cmd(32'h4000, 16'd64, lat);
        tog_en = 1'b0;
        n_checks++; if (rready_err - re !== 0) begin n_fail++; $display("FAIL toggle_rready: got %0d mismatched cycles required 0", rready_err - re); end
        n_checks++; if (n_dout - dout0 !== 8 || dout_bad !== 0 || last_at !== 7) begin n_fail++; $display("FAIL toggle_data: got beats %0d bad %0d last %0d required 8 0 7", n_dout - dout0, dout_bad, last_at); end
    endtask

    task automatic test_early_last;
        int lat;
        fill_resp(2'b00);
        early_idx = 1;
        run_cmd(32'h5000, 16'd32, lat);
        early_idx = -1;
        n_checks++; if (st_resp !== 2'b10) begin n_fail++; $display("FAIL early_last_status: got %b required 10", st_resp); end
        n_checks++; if (n_dout - dout0 !== 4 || last_at !== 3) begin n_fail++; $display("FAIL early_last_beats: got %0d last %0d required 4 3", n_dout - dout0, last_at); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        seen = 1'b0;
        fill_resp(2'b00);
        s0 = n_status; dout0 = n_dout; gbeat0 = gbeat; exp_base = 32'h7000;
        @(posedge clk); #1;
        ctrl_valid = 1'b1; ctrl_address = 32'h7000; ctrl_bytes = 16'd128;
        @(posedge clk); #1;
        ctrl_valid = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (n_dout - dout0 >= 3) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_reach_data: got %0d beats required 3", n_dout - dout0); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ctrl_ready !== 1'b1 || busy !== 1'b0 || bus.m_arvalid !== 1'b0 || status_valid !== 1'b0)
            begin n_fail++; $display("FAIL rmid_ctrl_outputs: got ready %b busy %b arvalid %b status %b required 1 0 0 0", ctrl_ready, busy, bus.m_arvalid, status_valid); end
        n_checks++; if (bus.m_araddr !== 32'h0 || bus.m_arlen !== 8'h0 || dout_valid !== 1'b0 || bus.m_rready !== 1'b0)
            begin n_fail++; $display("FAIL rmid_bus_outputs: got %h %h dv %b rr %b required 0 0 0 0", bus.m_araddr, bus.m_arlen, dout_valid, bus.m_rready); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (n_status - s0 !== 0) begin n_fail++; $display("FAIL rmid_no_status: got %0d pulses required 0", n_status - s0); end
        run_cmd(32'h8000, 16'd16, lat);
        n_checks++; if (ar_addr_q.size() - a0 !== 1 || n_dout - dout0 !== 2 || st_resp !== 2'b00 || dout_bad !== 0)
            begin n_fail++; $display("FAIL rmid_recover: got ARs %0d beats %0d resp %b bad %0d required 1 2 00 0", ar_addr_q.size() - a0, n_dout - dout0, st_resp, dout_bad); end
    endtask

    task automatic test_back_to_back;
        int st_cyc, acc2;
        bit acc;
        st_cyc = -1; acc2 = -1; acc = 1'b0;
        fill_resp(2'b00);
        a0 = ar_addr_q.size(); s0 = n_status; dout0 = n_dout; gbeat0 = gbeat; exp_base = 32'h6000;
        @(posedge clk); #1;
        ctrl_valid = 1'b1; ctrl_address = 32'h6000; ctrl_bytes = 16'd8;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (ctrl_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        ctrl_address = 32'h6008;
        for (int i = 0; i < 100 && acc2 < 0; i++) begin
            @(negedge clk);
            if (status_valid && st_cyc < 0) st_cyc = cyc;
            else if (ctrl_ready && st_cyc >= 0) acc2 = cyc;
        end
        @(posedge clk); #1;
        ctrl_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (acc2 - st_cyc !== 1 || st_cyc < 0) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d required 1", acc2 - st_cyc); end
        n_checks++; if (ar_addr_q.size() - a0 !== 2) begin n_fail++; $display("FAIL b2b_ar_count: got %0d required 2", ar_addr_q.size() - a0); end
        else begin
            n_checks++; if (ar_addr_q[a0] !== 32'h6000 || ar_addr_q[a0+1] !== 32'h6008 || ar_len_q[a0+1] !== 8'd0)
                begin n_fail++; $display("FAIL b2b_ar: got %h %h len %0d required 6000 6008 len 0", ar_addr_q[a0], ar_addr_q[a0+1], ar_len_q[a0+1]); end
        end
        n_checks++; if (n_status - s0 !== 2 || st_resp !== 2'b00 || dout_bad !== 0) begin n_fail++; $display("FAIL b2b_status: got %0d pulses resp %b bad %0d required 2 00 0", n_status - s0, st_resp, dout_bad); end
    endtask

    initial begin
        fill_resp(2'b00);
        test_reset;
        test_single_burst;
        test_unaligned;
        test_4kb_boundary;
        test_zero_bytes;
        test_errors;
        test_ar_stall;
        test_rready_toggle;
        test_early_last;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_burst_seq.md
Name: axi_rd_burst_seq

Overview:
- Read-side AXI4 master sequencer.
- Accepts one read command (start address + byte count, same layout as AxiMasterRdCtrl_t), splits it into legal INCR bursts, drives AR, counts R beats, streams data out, and reports one aggregated AxiResp_t at the end.
- Sits between a DMA/descriptor engine and the AXI interconnect.
- Exactly one burst is outstanding at a time.

Parameters:
- DATA_W, 64, R data width in bits (power of 2, 8..1024); BEAT_BYTES = DATA_W/8.
- ID_W, 4, AXI ID width.
- ARID_VAL, 0, constant ARID driven on every burst.
- MAX_BEATS, 16, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_valid  in  1  command valid
- ctrl_ready  out  1  command accept
- ctrl_address  in  32  start byte address
- ctrl_bytes  in  16  byte count
- status_valid  out  1  one-cycle completion pulse
- status_resp  out  2  aggregated AxiResp_t
- busy  out  1  command in progress
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_araddr  out  32  burst address
- m_arlen  out  8  beats-1
- m_arsize  out  3  log2(BEAT_BYTES), constant
- m_arburst  out  2  INCR, constant
- m_arid  out  ID_W  ARID_VAL
- m_arcache  out  4  AxiCache_t, constant 4'b0011
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- m_rdata  in  DATA_W  R data
- m_rresp  in  2  R response
- m_rlast  in  1  R last
- dout_valid  out  1  data-out valid
- dout_ready  in  1  data-out ready
- dout_data  out  DATA_W  data-out word
- dout_last  out  1  final beat of the whole command

Behaviour:
- Reset values: ctrl_ready=1, m_arvalid=0, status_valid=0, status_resp=OKAY, busy=0, m_araddr=0, m_arlen=0. Reset asserted mid-command aborts it silently; no status is issued.
- FSM states: IDLE, CALC, ADDR, DATA, DONE.
- IDLE: ctrl_ready=1. On ctrl_valid&&ctrl_ready:
  - latch cur_addr = ctrl_address aligned down to BEAT_BYTES;
  - latch beats_left = ceil((ctrl_address mod BEAT_BYTES + ctrl_bytes)/BEAT_BYTES), computed in 17+ bits, no truncation;
  - clear err_acc to OKAY; go to CALC.
  - ctrl_bytes==0: no AR is issued; go directly to DONE with OKAY.
- CALC (1 cycle): len = min(beats_left, MAX_BEATS, (4096 - cur_addr[11:0])/BEAT_BYTES). m_araddr=cur_addr, m_arlen=len-1. Go to ADDR.
- ADDR: m_arvalid=1; m_araddr and m_arlen hold stable until m_arready. On handshake go to DATA and load beat_cnt=len.
- DATA:
  - m_rready = dout_ready; dout_valid = m_rvalid; dout_data = m_rdata. Zero-cycle passthrough, no buffering.
  - On each R handshake: beat_cnt--. Merge err_acc = max(err_acc, map(m_rresp)), where map(EXOKAY)=OKAY.
  - Protocol check: m_rlast must equal (beat_cnt==1). On mismatch, merge SLVERR into err_acc; beat_cnt stays authoritative.
  - On last beat of the burst: beats_left -= len, cur_addr += len*BEAT_BYTES. If beats_left==0 go to DONE, else go to CALC.
  - dout_last=1 only on the final beat of the final burst.
- DONE (1 cycle): status_valid=1, status_resp=err_acc; go to IDLE.
- busy=1 in every state except IDLE.
- Bursts never cross a 4 KB boundary.
- An error does not stop the sequence; all bursts are still issued.
- Address increments wrap at 2^32 without a flag.
- Back-to-back commands: the earliest next accept is the cycle after DONE.

Test Plan:
- DATA_W=64, addr 0x1000, bytes 128 -> one AR (addr 0x1000, len 15); 16 dout beats; dout_last on beat 16; status OKAY.
- addr 0x1004, bytes 8 -> 2 beats; AR addr 0x1000, len 1; status OKAY.
- addr 0x0FF0, bytes 64 -> AR 0x0FF0 len 1, then AR 0x1000 len 5; no 4 KB crossing; 8 beats total.
- bytes 0 -> no m_arvalid; status_valid one cycle after accept with OKAY.
- 3 bursts with rresp SLVERR on burst 2 beat 3 -> all 3 bursts still complete; status SLVERR. A DECERR on a later beat -> status DECERR. EXOKAY everywhere -> status OKAY.
- Stall coverage: m_arready held low 5 cycles -> araddr/arlen stable; dout_ready toggling -> m_rready follows it; early m_rlast -> status SLVERR.
- rst_n asserted during DATA -> all outputs at reset values immediately; no status_valid; next command runs cleanly.
